// File: rtl/sram_wait_ctrl_if.sv
// Request/response side of the external SRAM wait-state controller.
// The requester (CPU/UART address mux) is the master; the controller is the slave.
interface sram_wait_ctrl_if;
   logic        req_sel;
   logic [15:0] req_addr;
   logic        req_r;
   logic [1:0]  req_w;
   logic [15:0] req_wdata;
   logic [15:0] rdata;
   logic        ready;
   logic        busy;

   modport master (
      output req_sel, req_addr, req_r, req_w, req_wdata,
      input  rdata, ready, busy
   );

   modport slave (
      input  req_sel, req_addr, req_r, req_w, req_wdata,
      output rdata, ready, busy
   );
endinterface

// File: rtl/sram_wait_ctrl.sv
// Registered Moore FSM generating setup/strobe/hold phases for a 16-bit async SRAM.
// Each request is captured in IDLE; ready pulses for one cycle in DONE.
module sram_wait_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 18
) (
   input  logic              clk,
   input  logic              nreset,
   sram_wait_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [15:0]       sram_dq,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [14:0] addr_q, addr_d;
   logic        is_rd_q, is_rd_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;

   logic        ce_n_q, ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        ub_n_q, ub_n_d;
   logic        lb_n_q, lb_n_d;
   logic        dq_oe_q, dq_oe_d;
   logic        ready_q, ready_d;

   logic        req_valid;
   logic        active_d;
   logic        unused_addr_lsb;

   assign req_valid       = bus.req_sel & (bus.req_r | (|bus.req_w));
   assign unused_addr_lsb = bus.req_addr[0];

   // Next state and request capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      is_rd_d = is_rd_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = bus.req_addr[15:1];
               is_rd_d = bus.req_r;
               // A read enables both lanes and overrides any write enables.
               be_d    = bus.req_r ? 2'b11 : bus.req_w;
               wdata_d = bus.req_wdata;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (is_rd_q) begin
                  rdata_d = sram_dq;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every SRAM output is a flop.
   always_comb begin
      active_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
      ce_n_d   = ~active_d;
      oe_n_d   = ~((state_d == ST_ACCESS) & is_rd_d);
      we_n_d   = ~((state_d == ST_ACCESS) & ~is_rd_d);
      ub_n_d   = ~(active_d & be_d[1]);
      lb_n_d   = ~(active_d & be_d[0]);
      dq_oe_d  = active_d & ~is_rd_d;
      ready_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 15'd0;
         is_rd_q <= 1'b0;
         be_q    <= 2'b00;
         wdata_q <= 16'd0;
         rdata_q <= 16'd0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         is_rd_q <= is_rd_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
         dq_oe_q <= dq_oe_d;
         ready_q <= ready_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = (state_q != ST_IDLE);

   assign sram_addr = ADDR_W'(addr_q);
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_ub_n = ub_n_q;
   assign sram_lb_n = lb_n_q;
   assign sram_dq   = dq_oe_q ? wdata_q : 16'hzzzz;

endmodule
